// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect request and the
// decoded-instruction handshake toward the decode stage.
interface instruction_fetch_if;
    // Handshake: instr_valid is asserted by the fetch unit while an assembled
    // instruction is held; the instruction transfers on a rising clk edge where
    // instr_valid and instr_ready are both 1. Once raised, instr_valid and all
    // instr_* fields stay stable until that transfer or a redirect/reset.
    logic [4:0] imem_addr;
    logic [7:0] imem_data;
    logic       redirect_valid;
    logic [4:0] redirect_addr;
    logic       instr_ready;
    logic       instr_valid;
    logic [3:0] instr_opcode;
    logic [3:0] instr_operand;
    logic [7:0] instr_imm;
    logic       instr_two_byte;
    logic [4:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_addr,
        input  instr_ready,
        output instr_valid,
        output instr_opcode,
        output instr_operand,
        output instr_imm,
        output instr_two_byte,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_addr,
        output instr_ready,
        input  instr_valid,
        input  instr_opcode,
        input  instr_operand,
        input  instr_imm,
        input  instr_two_byte,
        input  instr_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: assembles one- or two-byte instructions from a
// 32-byte combinational memory and holds each one until decode accepts it.
module instruction_fetch #(
    parameter logic [15:0] TWO_BYTE_MASK = 16'h0038
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_if.master        bus,
    output logic [1:0]                 dbg_state_o
);

    typedef enum logic [1:0] {
        S_FETCH0 = 2'd0,
        S_FETCH1 = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    state_e     state_q;
    logic [4:0] pc_q;
    logic       valid_q;
    logic [3:0] opcode_q;
    logic [3:0] operand_q;
    logic [7:0] imm_q;
    logic       two_byte_q;
    logic [4:0] instr_pc_q;

    logic [4:0] pc_d;
    logic       two_byte_d;

    // 5-bit add wraps 31 -> 0 naturally, so byte1 of an instruction at 31 comes from 0.
    always_comb begin
        pc_d       = pc_q + 5'd1;
        two_byte_d = TWO_BYTE_MASK[bus.imem_data[7:4]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            operand_q  <= '0;
            imm_q      <= '0;
            two_byte_q <= 1'b0;
            instr_pc_q <= '0;
        end else if (bus.redirect_valid) begin
            // A redirect wins in every state; any held instruction is dropped.
            pc_q    <= bus.redirect_addr;
            state_q <= S_FETCH0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH0: begin
                    opcode_q   <= bus.imem_data[7:4];
                    operand_q  <= bus.imem_data[3:0];
                    instr_pc_q <= pc_q;
                    pc_q       <= pc_d;
                    two_byte_q <= two_byte_d;
                    if (two_byte_d) begin
                        state_q <= S_FETCH1;
                    end else begin
                        imm_q   <= 8'h00;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_FETCH1: begin
                    imm_q   <= bus.imem_data;
                    pc_q    <= pc_d;
                    valid_q <= 1'b1;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_FETCH0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_FETCH0;
                end
            endcase
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = valid_q;
    assign bus.instr_opcode   = opcode_q;
    assign bus.instr_operand  = operand_q;
    assign bus.instr_imm      = imm_q;
    assign bus.instr_two_byte = two_byte_q;
    assign bus.instr_pc       = instr_pc_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized stream
// checked against an address-walking reference model of the instruction memory.
module tb_instruction_fetch;

    localparam logic [15:0] MASK = 16'h0038;
    localparam int W = 22;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    logic [7:0] mem [32];

    int chk_cnt;
    int pass_cnt;
    logic [W-1:0] exp_q [$];
    logic [4:0] model_pc;

    instruction_fetch_if bus ();

    instruction_fetch #(.TWO_BYTE_MASK(MASK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, opcode, operand, imm, two_byte}
    function automatic logic [W-1:0] obs_instr();
        return {bus.instr_pc, bus.instr_opcode, bus.instr_operand, bus.instr_imm, bus.instr_two_byte};
    endfunction

    function automatic logic [W-1:0] model_instr(input logic [4:0] pc);
        logic [7:0] b0;
        logic [7:0] b1;
        logic       two;
        b0  = mem[pc];
        two = MASK[b0[7:4]];
        b1  = two ? mem[5'((int'(pc) + 1) % 32)] : 8'h00;
        return {pc, b0[7:4], b0[3:0], b1, two};
    endfunction

    function automatic logic [4:0] model_next(input logic [4:0] pc);
        logic two;
        two = MASK[mem[pc][7:4]];
        return 5'((int'(pc) + 1 + int'(two)) % 32);
    endfunction

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic redirect_to(input logic [4:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.instr_valid);
        else pass_cnt++;
        chk_cnt++;
        if (obs_instr() !== '0) $display("FAIL reset_fields: got %h want 0", obs_instr());
        else pass_cnt++;
        chk_cnt++;
        if (bus.imem_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", bus.imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        mem[0] = 8'h35;
        mem[1] = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd1)
            $display("FAIL first_fetch1: got valid=%b addr=%0d want valid=0 addr=1", bus.instr_valid, bus.imem_addr);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.instr_valid !== 1'b1 || obs_instr() !== {5'd0, 4'h3, 4'h5, 8'h00, 1'b1})
            $display("FAIL first_instr: got valid=%b f=%h want valid=1 f=%h", bus.instr_valid, obs_instr(),
                     {5'd0, 4'h3, 4'h5, 8'h00, 1'b1});
        else pass_cnt++;
        chk_cnt++;
        if (bus.imem_addr !== 5'd2) $display("FAIL first_next_addr: got %0d want 2", bus.imem_addr);
        else pass_cnt++;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk_cnt++;
        if (bus.instr_valid !== 1'b0) $display("FAIL first_accept: got valid=%b want 0", bus.instr_valid);
        else pass_cnt++;
    endtask

    task automatic test_redirect_one_byte();
        mem[6] = 8'h20;
        redirect_to(5'd6);
        chk_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd6)
            $display("FAIL redir6_fetch0: got valid=%b addr=%0d want valid=0 addr=6", bus.instr_valid, bus.imem_addr);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.instr_valid !== 1'b1 || obs_instr() !== {5'd6, 4'h2, 4'h0, 8'h00, 1'b0})
            $display("FAIL redir6_instr: got valid=%b f=%h want valid=1 f=%h", bus.instr_valid, obs_instr(),
                     {5'd6, 4'h2, 4'h0, 8'h00, 1'b0});
        else pass_cnt++;
        chk_cnt++;
        if (bus.imem_addr !== 5'd7) $display("FAIL redir6_next_addr: got %0d want 7", bus.imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_hold_stall();
        logic [W-1:0] held;
        held = {5'd6, 4'h2, 4'h0, 8'h00, 1'b0};
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.instr_valid !== 1'b1 || obs_instr() !== held || bus.imem_addr !== 5'd7)
                $display("FAIL stall_cycle%0d: got valid=%b f=%h addr=%0d want valid=1 f=%h addr=7",
                         i, bus.instr_valid, obs_instr(), bus.imem_addr, held);
            else pass_cnt++;
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd7)
            $display("FAIL stall_release: got valid=%b addr=%0d want valid=0 addr=7", bus.instr_valid, bus.imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_redirect_in_fetch1();
        bit ok;
        mem[11] = 8'h42;
        redirect_to(5'd11);
        @(negedge clk);
        chk_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd12)
            $display("FAIL fetch1_state: got valid=%b addr=%0d want valid=0 addr=12", bus.instr_valid, bus.imem_addr);
        else pass_cnt++;
        redirect_to(5'd18);
        chk_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd18)
            $display("FAIL fetch1_redirect: got valid=%b addr=%0d want valid=0 addr=18", bus.instr_valid, bus.imem_addr);
        else pass_cnt++;
        wait_valid(4, ok);
        chk_cnt++;
        if (!ok || obs_instr() !== model_instr(5'd18))
            $display("FAIL fetch1_next_instr: got ok=%b f=%h want f=%h", ok, obs_instr(), model_instr(5'd18));
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        mem[31] = 8'h4A;
        mem[0]  = 8'h07;
        redirect_to(5'd31);
        wait_valid(4, ok);
        chk_cnt++;
        if (!ok || obs_instr() !== {5'd31, 4'h4, 4'hA, 8'h07, 1'b1})
            $display("FAIL wrap_instr: got ok=%b f=%h want f=%h", ok, obs_instr(), {5'd31, 4'h4, 4'hA, 8'h07, 1'b1});
        else pass_cnt++;
        chk_cnt++;
        if (bus.imem_addr !== 5'd1) $display("FAIL wrap_next_addr: got %0d want 1", bus.imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        @(negedge clk);
        chk_cnt++;
        if (bus.instr_valid !== 1'b1) $display("FAIL rst_hold_pre: got valid=%b want 1", bus.instr_valid);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.instr_valid !== 1'b0 || obs_instr() !== '0 || bus.imem_addr !== 5'd0)
            $display("FAIL rst_hold_async: got valid=%b f=%h addr=%0d want all 0", bus.instr_valid, obs_instr(), bus.imem_addr);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(4, ok);
        chk_cnt++;
        if (!ok || obs_instr() !== model_instr(5'd0))
            $display("FAIL rst_hold_restart: got ok=%b f=%h want f=%h", ok, obs_instr(), model_instr(5'd0));
        else pass_cnt++;
    endtask

    task automatic test_random_stream();
        int accepted;
        logic [W-1:0] exp;
        accepted = 0;
        for (int a = 0; a < 32; a++) mem[a] = 8'($urandom_range(0, 255));
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            if (cyc == 0 || $urandom_range(0, 24) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_addr  = 5'($urandom_range(0, 31));
                exp_q.delete();
                model_pc = bus.redirect_addr;
            end else begin
                bus.instr_ready = 1'($urandom_range(0, 1));
                if (bus.instr_valid && bus.instr_ready) begin
                    exp = exp_q.pop_front();
                    accepted++;
                    chk_cnt++;
                    if (obs_instr() !== exp)
                        $display("FAIL rand_instr%0d: got %h want %h", accepted, obs_instr(), exp);
                    else pass_cnt++;
                end
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back(model_instr(model_pc));
                model_pc = model_next(model_pc);
            end
        end
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        chk_cnt++;
        if (accepted < 20) $display("FAIL rand_progress: got %0d accepted want >= 20", accepted);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.instr_ready    = 1'b0;
        for (int a = 0; a < 32; a++) mem[a] = 8'($urandom_range(0, 255));
        test_reset();
        test_first_fetch();
        test_redirect_one_byte();
        test_hold_stall();
        test_redirect_in_fetch1();
        test_wrap();
        test_reset_in_hold();
        test_random_stream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter TWO_BYTE_MASK, default 16'h0038, where bit n set means opcode nibble n is a two-byte instruction (nibbles 3, 4, 5).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_addr, output, 5, byte address to instruction memory.
REQ-005 SHALL have port imem_data, input, 8, combinational read data for imem_addr.
REQ-006 SHALL have port redirect_valid, input, 1, jump/branch request.
REQ-007 SHALL have port redirect_addr, input, 5, jump target byte address.
REQ-008 SHALL have port instr_ready, input, 1, downstream decode stage accepts the instruction.
REQ-009 SHALL have port instr_valid, output, 1, assembled instruction available.
REQ-010 SHALL have port instr_opcode, output, 4, imem byte0 [7:4].
REQ-011 SHALL have port instr_operand, output, 4, imem byte0 [3:0].
REQ-012 SHALL have port instr_imm, output, 8, byte1 for two-byte instructions, 8'h00 otherwise.
REQ-013 SHALL have port instr_two_byte, output, 1, set when the instruction is two bytes long.
REQ-014 SHALL have port instr_pc, output, 5, address of byte0.

Function
REQ-015 SHALL hold a 5-bit PC and states FETCH0, FETCH1, HOLD; imem_addr SHALL equal the PC in every state.
REQ-016 FETCH0: SHALL latch imem_data as byte0, latch PC as instr_pc, and set PC = PC+1.
REQ-017 FETCH0: SHALL go to FETCH1 if TWO_BYTE_MASK[imem_data[7:4]] is set, else clear instr_imm and go to HOLD.
REQ-018 FETCH1: SHALL latch imem_data into instr_imm, set PC = PC+1, and go to HOLD.
REQ-019 SHALL assert instr_valid only in HOLD; all instr_* outputs are registered and stable while in HOLD.
REQ-020 HOLD with instr_ready=1: SHALL complete the handshake and go to FETCH0; with instr_ready=0 it SHALL stay in HOLD with outputs unchanged.
REQ-021 Latency: instr_valid SHALL rise 1 cycle after entering FETCH0 for one-byte instructions and 2 cycles after for two-byte instructions.
REQ-022 PC increment SHALL wrap modulo 32 (31 -> 0); a two-byte instruction at address 31 SHALL take byte1 from address 0.
REQ-023 redirect_valid=1 in any state SHALL load PC = redirect_addr, go to FETCH0, and discard any partially fetched or held instruction (instr_valid low next cycle).
REQ-024 redirect_valid and instr_ready both high in HOLD SHALL count the handshake as complete and take the redirect.
REQ-025 In FETCH0/FETCH1, instr_ready SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force PC=0, state FETCH0, instr_valid=0, and instr_opcode, instr_operand, instr_imm, instr_two_byte, instr_pc all 0.
REQ-027 Reset asserted mid-fetch or during HOLD SHALL abandon the instruction; after release, fetch SHALL restart at address 0.
REQ-028 The first rising clk edge after rst_n rises SHALL perform FETCH0 at address 0.

Verification
REQ-029 Memory addr0=8'h35, addr1=8'h00; release reset, instr_ready=1 -> 2 cycles later instr_valid=1, opcode=3, operand=5, imm=00, two_byte=1, pc=0; next fetch at addr 2.
REQ-030 Redirect to 6 with addr6=8'h20 -> 1 cycle after FETCH0, instr_valid=1, opcode=2, operand=0, imm=00, two_byte=0, pc=6; next FETCH0 at addr 7.
REQ-031 instr_ready held 0 for 5 cycles in HOLD -> instr_valid and all outputs constant for 5 cycles; PC unchanged; ready=1 -> FETCH0 next cycle.
REQ-032 Redirect to 18 asserted during FETCH1 of the addr11 instruction (8'h42) -> no instr_valid for pc=11; next valid instruction has pc=18.
REQ-033 Bench memory addr31=8'h4A, addr0=8'h07; redirect to 31 -> instr_valid with opcode=4, operand=A, imm=07, pc=31; next fetch at addr 1.
REQ-034 rst_n pulsed low while in HOLD -> instr_valid=0 immediately (asynchronous); after release, first instruction reported has pc=0.
